fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter INSTR_MEM_SIZE, default 128, meaning the instruction memory size in bytes.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ByteAddr  output  32  byte address driven to the byte-wide instruction memory.
REQ-006 SHALL have port ByteData  input  8  combinational read data for ByteAddr, valid in the same cycle.
REQ-007 SHALL have port Instr  output  32  assembled instruction, big-endian: byte at PC in [31:24], PC+3 in [7:0].
REQ-008 SHALL have port InstrPC  output  32  PC of the instruction on Instr.
REQ-009 SHALL have port InstrValid  output  1  Instr and InstrPC hold a complete instruction.
REQ-010 SHALL have port InstrReady  input  1  the consumer accepts the instruction when InstrValid=1.
REQ-011 SHALL have port Redirect  input  1  one-cycle request to restart fetch at RedirectPC.
REQ-012 SHALL have port RedirectPC  input  32  target PC, sampled when Redirect=1.
REQ-013 SHALL have port Fault  output  1  sticky flag for a misaligned or out-of-range PC.

Function
REQ-014 SHALL implement a 3-state FSM: FETCH, VALID, FAULT.
REQ-015 In FETCH, ByteAddr SHALL equal PC+ByteCnt, with ByteCnt a 2-bit counter running 0..3; each cycle, ByteData SHALL be written into the Instr byte lane (3-ByteCnt).
REQ-016 When FETCH completes with ByteCnt=3, the FSM SHALL enter VALID and drive InstrValid=1 and InstrPC=PC in the next cycle; fetch latency is therefore 4 cycles.
REQ-017 In VALID, Instr, InstrPC and InstrValid SHALL hold stable until InstrValid&&InstrReady.
REQ-018 On a VALID handshake, the block SHALL set PC<=PC+4, set ByteCnt<=0, clear InstrValid and enter FETCH; throughput is one instruction per 5 cycles when InstrReady is held at 1.
REQ-019 Redirect=1 in FETCH or VALID SHALL set PC<=RedirectPC, ByteCnt<=0 and InstrValid<=0, and enter FETCH.
REQ-020 Redirect SHALL take priority over a simultaneous handshake; the held instruction is discarded and PC+4 is not applied.
REQ-021 Before any entry to FETCH, the new PC SHALL be checked: if PC[1:0]!=0 or PC>INSTR_MEM_SIZE-4 (32-bit unsigned compare, no wrap), the FSM SHALL enter FAULT instead of FETCH.
REQ-022 This check SHALL cover RedirectPC and sequential PC+4; PC=124 followed by a handshake SHALL fault and SHALL NOT wrap to 0.
REQ-023 In FAULT, the block SHALL drive Fault=1 and InstrValid=0, hold ByteAddr at the faulting PC, and ignore Redirect and InstrReady until reset.
REQ-024 In VALID and FAULT, ByteAddr SHALL equal PC, and the memory read SHALL have no side effect.
REQ-025 All PC arithmetic SHALL be 32-bit unsigned with no carry-out retained.

Reset
REQ-026 While rst_n=0, the block SHALL force asynchronously: state=FETCH, PC=RESET_PC, ByteCnt=0, Instr=0, InstrPC=0, InstrValid=0, Fault=0, ByteAddr=RESET_PC.
REQ-027 Reset asserted mid-fetch or in VALID SHALL discard the partial or held instruction, with no output glitch to InstrValid=1.
REQ-028 After rst_n deasserts, the first instruction at RESET_PC SHALL appear with InstrValid=1 on the 5th rising edge.
REQ-029 An illegal RESET_PC SHALL cause FAULT on the first edge after reset.

Structure
REQ-030 The FSM state encoding and the INSTR_MEM_SIZE default SHALL live in a shared package, fetch_pkg.
REQ-031 The block SHALL be one module with one natural sub-module, fetch_pc_chk, a combinational alignment/range checker instantiated once on the next-PC mux.
REQ-032 The block SHALL contain no memory array; the memory remains external.

Verification
REQ-033 Scenario: memory bytes 0..7 = 8C,01,00,04,AC,02,00,08; reset; InstrReady=1 -> Instr=8C010004, InstrPC=0 on edge 5; then Instr=AC020008, InstrPC=4 five cycles later.
REQ-034 Scenario: InstrReady=0 for 10 cycles while VALID -> Instr, InstrPC and InstrValid stable; ByteAddr=PC; one handshake -> PC advances exactly 4.
REQ-035 Scenario: Redirect=1, RedirectPC=0x20 in the same cycle as a handshake at PC=4 -> next fetch at ByteAddr 0x20..0x23, the instruction at 8 is never presented, and InstrPC=0x20.
REQ-036 Scenario: RedirectPC=0x22 -> Fault=1 next cycle, InstrValid=0; later Redirect=1 to 0x00 is ignored.
REQ-037 Scenario: redirect to 0x7C, accept the instruction -> Fault=1, ByteAddr=0x80 held, no wrap to 0.
REQ-038 Scenario: rst_n pulsed low for a partial cycle after ByteCnt=2 -> outputs reset immediately without waiting for clk, and the restarted fetch delivers the RESET_PC instruction on edge 5.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared FSM encoding and default sizes for the instruction fetch controller
package fetch_pkg;

    localparam int INSTR_MEM_SIZE_DEF = 128;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_VALID = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_chk.sv
// rtl/fetch_pc_chk.sv - combinational alignment / range check of a candidate PC
//   pc    : candidate program counter (byte address)
//   pc_ok : 1 when pc is word aligned and pc+3 lies inside the instruction memory
module fetch_pc_chk #(
    parameter int MEM_SIZE = 128
) (
    input  logic [31:0] pc,
    output logic        pc_ok
);

    // Compare in 33 bits so that pc+4 can never wrap and MEM_SIZE < 4 cannot underflow.
    localparam logic [32:0] MEM_END = 33'(MEM_SIZE);

    logic [32:0] pc_end;

    assign pc_end = {1'b0, pc} + 33'd4;
    assign pc_ok  = (pc[1:0] == 2'b00) && (pc_end <= MEM_END);

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - byte-serial instruction fetch with valid/ready handoff, redirect and sticky fault
//   clk, rst_n          : clock, asynchronous active-low reset
//   ByteAddr / ByteData : byte-wide external instruction memory (combinational read)
//   Instr / InstrPC     : assembled big-endian instruction and its PC
//   InstrValid / InstrReady : output handshake
//   Redirect / RedirectPC   : one-cycle restart request and its target
//   Fault               : sticky misaligned / out-of-range PC flag, cleared only by reset
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int          INSTR_MEM_SIZE = INSTR_MEM_SIZE_DEF,
    parameter logic [31:0] RESET_PC       = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] ByteAddr,
    input  logic [7:0]  ByteData,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    output logic        InstrValid,
    input  logic        InstrReady,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        Fault
);

    fetch_state_e state, state_next;
    logic [31:0]  pc, pc_next;
    logic [1:0]   byte_cnt;
    logic [31:0]  instr_q;
    logic [31:0]  instr_pc_q;
    logic         pc_ok;
    logic         restart;
    logic         fetch_step;

    fetch_pc_chk #(
        .MEM_SIZE (INSTR_MEM_SIZE)
    ) u_pc_chk (
        .pc    (pc_next),
        .pc_ok (pc_ok)
    );

    // Next-PC mux and state transition. Redirect wins over a handshake.
    // In FETCH without a redirect, pc_next equals pc, so the same checker
    // also catches an illegal RESET_PC on the first edge after reset.
    always_comb begin
        pc_next    = pc;
        state_next = state;
        restart    = 1'b0;
        fetch_step = 1'b0;
        case (state)
            ST_FETCH: begin
                if (Redirect) begin
                    pc_next = RedirectPC;
                    restart = 1'b1;
                end else if (byte_cnt == 2'd3) begin
                    state_next = ST_VALID;
                end
            end
            ST_VALID: begin
                if (Redirect) begin
                    pc_next = RedirectPC;
                    restart = 1'b1;
                end else if (InstrReady) begin
                    pc_next = pc + 32'd4;
                    restart = 1'b1;
                end
            end
            default: begin
                // FAULT is terminal until reset; Redirect and InstrReady are ignored.
            end
        endcase

        if ((restart || (state == ST_FETCH)) && !pc_ok) begin
            state_next = ST_FAULT;
        end else if (restart) begin
            state_next = ST_FETCH;
        end

        fetch_step = (state == ST_FETCH) && !restart && (state_next != ST_FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_FETCH;
            pc         <= RESET_PC;
            byte_cnt   <= 2'd0;
            instr_q    <= 32'd0;
            instr_pc_q <= 32'd0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (fetch_step) begin
                case (byte_cnt)
                    2'd0:    instr_q[31:24] <= ByteData;
                    2'd1:    instr_q[23:16] <= ByteData;
                    2'd2:    instr_q[15:8]  <= ByteData;
                    default: instr_q[7:0]   <= ByteData;
                endcase
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    instr_pc_q <= pc;
                end
            end else begin
                byte_cnt <= 2'd0;
            end
        end
    end

    // Outside FETCH the address parks on PC; the read has no side effect.
    assign ByteAddr   = (state == ST_FETCH) ? (pc + {30'd0, byte_cnt}) : pc;
    assign Instr      = instr_q;
    assign InstrPC    = instr_pc_q;
    assign InstrValid = (state == ST_VALID);
    assign Fault      = (state == ST_FAULT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking scoreboard bench for fetch_ctrl
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ByteAddr;
    logic [7:0]  ByteData;
    logic [31:0] Instr;
    logic [31:0] InstrPC;
    logic        InstrValid;
    logic        InstrReady = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectPC = 32'd0;
    logic        Fault;

    int pass_cnt  = 0;
    int check_cnt = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    logic [7:0] mem [0:127];

    fetch_ctrl #(
        .INSTR_MEM_SIZE (128),
        .RESET_PC       (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ByteAddr   (ByteAddr),
        .ByteData   (ByteData),
        .Instr      (Instr),
        .InstrPC    (InstrPC),
        .InstrValid (InstrValid),
        .InstrReady (InstrReady),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .Fault      (Fault)
    );

    always #5 clk = ~clk;

    assign ByteData = (ByteAddr < 32'd128) ? mem[ByteAddr[6:0]] : 8'h00;

    function automatic exp_t make_exp(input logic [31:0] a);
        exp_t e;
        logic [6:0] b;
        b       = a[6:0];
        e.pc    = a;
        e.instr = {mem[b], mem[b + 7'd1], mem[b + 7'd2], mem[b + 7'd3]};
        return e;
    endfunction

    // Returns the number of rising edges until InstrValid is seen at a falling edge.
    task automatic wait_valid(input int max, output int n);
        n = max + 1;
        for (int i = 1; i <= max; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (InstrValid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; InstrReady = 1'b0; Redirect = 1'b0; RedirectPC = 32'd0;
        sb.delete();
        @(negedge clk);
        check_cnt++; if (InstrValid !== 1'b0) $display("FAIL reset_valid got %b want 0", InstrValid); else pass_cnt++;
        check_cnt++; if (Fault !== 1'b0) $display("FAIL reset_fault got %b want 0", Fault); else pass_cnt++;
        check_cnt++; if (ByteAddr !== 32'h0) $display("FAIL reset_addr got %h want 0", ByteAddr); else pass_cnt++;
        check_cnt++; if (Instr !== 32'h0) $display("FAIL reset_instr got %h want 0", Instr); else pass_cnt++;
        check_cnt++; if (InstrPC !== 32'h0) $display("FAIL reset_instrpc got %h want 0", InstrPC); else pass_cnt++;
    endtask

    task automatic test_sequential();
        int   n;
        exp_t e;
        sb.push_back(make_exp(32'h0));
        sb.push_back(make_exp(32'h4));
        InstrReady = 1'b1;
        rst_n = 1'b1;
        wait_valid(8, n);
        // valid before edge 5, accepted on edge 5
        check_cnt++; if (n !== 4) $display("FAIL first_latency got %0d want 4", n); else pass_cnt++;
        e = sb.pop_front();
        check_cnt++; if (Instr !== e.instr) $display("FAIL seq0_instr got %h want %h", Instr, e.instr); else pass_cnt++;
        check_cnt++; if (InstrPC !== e.pc) $display("FAIL seq0_pc got %h want %h", InstrPC, e.pc); else pass_cnt++;
        check_cnt++; if (Instr !== 32'h8C010004) $display("FAIL seq0_const got %h want 8c010004", Instr); else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        InstrReady = 1'b0;
        check_cnt++; if (InstrValid !== 1'b0) $display("FAIL valid_drop got %b want 0", InstrValid); else pass_cnt++;
        wait_valid(8, n);
        check_cnt++; if (n !== 4) $display("FAIL second_latency got %0d want 4", n); else pass_cnt++;
        e = sb.pop_front();
        check_cnt++; if (Instr !== e.instr) $display("FAIL seq1_instr got %h want %h", Instr, e.instr); else pass_cnt++;
        check_cnt++; if (InstrPC !== e.pc) $display("FAIL seq1_pc got %h want %h", InstrPC, e.pc); else pass_cnt++;
        check_cnt++; if (Instr !== 32'hAC020008) $display("FAIL seq1_const got %h want ac020008", Instr); else pass_cnt++;
    endtask

    task automatic test_stall();
        exp_t e;
        e = make_exp(32'h4);
        InstrReady = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_cnt++;
            if (InstrValid !== 1'b1 || Instr !== e.instr || InstrPC !== e.pc || ByteAddr !== e.pc)
                $display("FAIL stall_hold cyc %0d got v=%b i=%h pc=%h a=%h want v=1 i=%h pc=%h a=%h",
                         k, InstrValid, Instr, InstrPC, ByteAddr, e.instr, e.pc, e.pc);
            else pass_cnt++;
        end
    endtask

    task automatic test_redirect();
        int   n;
        exp_t e;
        sb.push_back(make_exp(32'h20));
        Redirect = 1'b1; RedirectPC = 32'h20; InstrReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        Redirect = 1'b0; InstrReady = 1'b0;
        check_cnt++; if (InstrValid !== 1'b0) $display("FAIL redir_valid got %b want 0", InstrValid); else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            check_cnt++;
            if (ByteAddr !== 32'h20 + 32'(k)) $display("FAIL redir_addr got %h want %h", ByteAddr, 32'h20 + 32'(k));
            else pass_cnt++;
            if (k < 3) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        wait_valid(4, n);
        check_cnt++; if (n !== 1) $display("FAIL redir_latency got %0d want 1", n); else pass_cnt++;
        e = sb.pop_front();
        check_cnt++; if (Instr !== e.instr) $display("FAIL redir_instr got %h want %h", Instr, e.instr); else pass_cnt++;
        check_cnt++; if (InstrPC !== e.pc) $display("FAIL redir_pc got %h want %h", InstrPC, e.pc); else pass_cnt++;
        // one handshake advances PC by exactly 4
        sb.push_back(make_exp(32'h24));
        InstrReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        InstrReady = 1'b0;
        check_cnt++; if (ByteAddr !== 32'h24) $display("FAIL advance_4 got %h want 24", ByteAddr); else pass_cnt++;
        wait_valid(8, n);
        check_cnt++; if (n !== 4) $display("FAIL adv_latency got %0d want 4", n); else pass_cnt++;
        e = sb.pop_front();
        check_cnt++; if (Instr !== e.instr) $display("FAIL adv_instr got %h want %h", Instr, e.instr); else pass_cnt++;
        check_cnt++; if (InstrPC !== e.pc) $display("FAIL adv_pc got %h want %h", InstrPC, e.pc); else pass_cnt++;
    endtask

    task automatic test_fault_misaligned();
        Redirect = 1'b1; RedirectPC = 32'h22;
        @(posedge clk);
        @(negedge clk);
        Redirect = 1'b0;
        check_cnt++; if (Fault !== 1'b1) $display("FAIL mis_fault got %b want 1", Fault); else pass_cnt++;
        check_cnt++; if (InstrValid !== 1'b0) $display("FAIL mis_valid got %b want 0", InstrValid); else pass_cnt++;
        check_cnt++; if (ByteAddr !== 32'h22) $display("FAIL mis_addr got %h want 22", ByteAddr); else pass_cnt++;
        Redirect = 1'b1; RedirectPC = 32'h0; InstrReady = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        Redirect = 1'b0; InstrReady = 1'b0;
        check_cnt++; if (Fault !== 1'b1) $display("FAIL mis_sticky got %b want 1", Fault); else pass_cnt++;
        check_cnt++; if (ByteAddr !== 32'h22) $display("FAIL mis_ignore_redir got %h want 22", ByteAddr); else pass_cnt++;
        check_cnt++; if (InstrValid !== 1'b0) $display("FAIL mis_valid_hold got %b want 0", InstrValid); else pass_cnt++;
    endtask

    task automatic test_fault_range();
        int   n;
        exp_t e;
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1; InstrReady = 1'b0;
        check_cnt++; if (Fault !== 1'b0) $display("FAIL rng_reset_fault got %b want 0", Fault); else pass_cnt++;
        wait_valid(8, n);
        check_cnt++; if (n !== 4) $display("FAIL rng_first_latency got %0d want 4", n); else pass_cnt++;
        sb.push_back(make_exp(32'h7C));
        Redirect = 1'b1; RedirectPC = 32'h7C;
        @(posedge clk);
        @(negedge clk);
        Redirect = 1'b0;
        wait_valid(8, n);
        check_cnt++; if (n !== 4) $display("FAIL rng_latency got %0d want 4", n); else pass_cnt++;
        e = sb.pop_front();
        check_cnt++; if (Instr !== e.instr) $display("FAIL rng_instr got %h want %h", Instr, e.instr); else pass_cnt++;
        check_cnt++; if (InstrPC !== e.pc) $display("FAIL rng_pc got %h want %h", InstrPC, e.pc); else pass_cnt++;
        InstrReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        InstrReady = 1'b0;
        check_cnt++; if (Fault !== 1'b1) $display("FAIL rng_fault got %b want 1", Fault); else pass_cnt++;
        check_cnt++; if (ByteAddr !== 32'h80) $display("FAIL rng_addr got %h want 80", ByteAddr); else pass_cnt++;
        check_cnt++; if (InstrValid !== 1'b0) $display("FAIL rng_valid got %b want 0", InstrValid); else pass_cnt++;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_cnt++; if (ByteAddr !== 32'h80) $display("FAIL rng_no_wrap got %h want 80", ByteAddr); else pass_cnt++;
    endtask

    task automatic test_reset_midfetch();
        int   n;
        exp_t e;
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1; InstrReady = 1'b1;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_cnt++; if (ByteAddr !== 32'h2) $display("FAIL mid_addr got %h want 2", ByteAddr); else pass_cnt++;
        #1 rst_n = 1'b0;
        #1;
        // still well before the next rising edge
        check_cnt++; if (ByteAddr !== 32'h0) $display("FAIL mid_async_addr got %h want 0", ByteAddr); else pass_cnt++;
        check_cnt++; if (Instr !== 32'h0) $display("FAIL mid_async_instr got %h want 0", Instr); else pass_cnt++;
        check_cnt++; if (InstrValid !== 1'b0) $display("FAIL mid_async_valid got %b want 0", InstrValid); else pass_cnt++;
        check_cnt++; if (Fault !== 1'b0) $display("FAIL mid_async_fault got %b want 0", Fault); else pass_cnt++;
        #1 rst_n = 1'b1;
        sb.push_back(make_exp(32'h0));
        wait_valid(8, n);
        check_cnt++; if (n !== 4) $display("FAIL mid_restart_latency got %0d want 4", n); else pass_cnt++;
        e = sb.pop_front();
        check_cnt++; if (Instr !== e.instr) $display("FAIL mid_instr got %h want %h", Instr, e.instr); else pass_cnt++;
        check_cnt++; if (InstrPC !== e.pc) $display("FAIL mid_pc got %h want %h", InstrPC, e.pc); else pass_cnt++;
        InstrReady = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'((i * 37 + 11) & 255);
        mem[0] = 8'h8C; mem[1] = 8'h01; mem[2] = 8'h00; mem[3] = 8'h04;
        mem[4] = 8'hAC; mem[5] = 8'h02; mem[6] = 8'h00; mem[7] = 8'h08;

        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_fault_misaligned();
        test_fault_range();
        test_reset_midfetch();

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
